// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, the send-side peer of uart_rx in the hangman link.
//
// Serialises one byte per accepted request as:
//   start(0), D0..D7 (LSB first), optional parity bit, stop(1).
// Every bit is held for exactly Clkperbaud clk cycles.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   tx_ctrl    in   1  send request
//   tx_byte    in   8  byte to send, captured when the request is accepted
//   tx_serial  out  1  serial line, idles high (registered)
//   tx_busy    out  1  frame in flight (registered)
//   tx_done    out  1  one-cycle pulse on the last cycle of STOP (registered)
//   tx_state   out  3  current FSM state, for observation only
//
// Request handshake: tx_ctrl is sampled only while the FSM sits in IDLE; a
// high sample there accepts the request and latches tx_byte in that same
// cycle. tx_busy rises on the following cycle and falls when the frame ends.
// Requests arriving outside IDLE are dropped, never queued; holding tx_ctrl
// high therefore starts a new frame each time the FSM passes through IDLE.
module uart_tx #(
  parameter int Clkperbaud = 1250,
  parameter bit ParityEn   = 1'b1,
  parameter bit ParityOdd  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_ctrl,
  input  logic [7:0] tx_byte,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [2:0] tx_state
);

  localparam int CW = $clog2(Clkperbaud);
  localparam logic [CW-1:0] CNT_MAX = CW'(Clkperbaud - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATAOUT = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_CLEAN   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d;
  logic            serial_d, busy_d, done_d;
  logic            bit_end;

  assign bit_end  = (cnt_q == CNT_MAX);
  assign tx_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      tx_serial <= serial_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (tx_ctrl) begin
          sh_d    = tx_byte;
          par_d   = (^tx_byte) ^ ParityOdd;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATAOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATAOUT: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ParityEn ? S_PARITY : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_CLEAN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLEAN: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and flopped, so the line
    // changes exactly on the edge that enters each bit and never glitches.
    case (state_d)
      S_START:   serial_d = 1'b0;
      S_DATAOUT: serial_d = sh_d[0];
      S_PARITY:  serial_d = par_d;
      default:   serial_d = 1'b1;
    endcase
    busy_d = (state_d == S_START) || (state_d == S_DATAOUT) ||
             (state_d == S_PARITY) || (state_d == S_STOP);
    done_d = (state_d == S_STOP) && (cnt_d == CNT_MAX);
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Four instances: 0 = 4 clk/bit even parity, 1 = 4 clk/bit odd parity,
// 2 = 4 clk/bit no parity, 3 = 1250 clk/bit even parity.
// Stimulus pushes {dut, parity, byte} into exp_q; a monitor per instance
// decodes each frame off tx_serial and compares against the queue head.
module tb_uart_tx;

  localparam int CPB [4] = '{4, 4, 4, 1250};
  localparam int PEN [4] = '{1, 1, 0, 1};

  // ---------------- clock / reset ----------------
  logic tb_clk = 1'b0;
  logic rst    = 1'b1;
  always #5 tb_clk = ~tb_clk;

  int cyc = 0;
  always @(posedge tb_clk) cyc <= cyc + 1;

  logic [3:0] tx_ctrl = '0;
  logic [7:0] tx_byte [4];
  wire  [3:0] ser, busy, done;
  wire  [2:0] st [4];

  uart_tx #(.Clkperbaud(4), .ParityEn(1'b1), .ParityOdd(1'b0)) u_dut0 (
    .clk(tb_clk), .rst(rst), .tx_ctrl(tx_ctrl[0]), .tx_byte(tx_byte[0]),
    .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]), .tx_state(st[0]));
  uart_tx #(.Clkperbaud(4), .ParityEn(1'b1), .ParityOdd(1'b1)) u_dut1 (
    .clk(tb_clk), .rst(rst), .tx_ctrl(tx_ctrl[1]), .tx_byte(tx_byte[1]),
    .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]), .tx_state(st[1]));
  uart_tx #(.Clkperbaud(4), .ParityEn(1'b0), .ParityOdd(1'b0)) u_dut2 (
    .clk(tb_clk), .rst(rst), .tx_ctrl(tx_ctrl[2]), .tx_byte(tx_byte[2]),
    .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]), .tx_state(st[2]));
  uart_tx #(.Clkperbaud(1250), .ParityEn(1'b1), .ParityOdd(1'b0)) u_dut3 (
    .clk(tb_clk), .rst(rst), .tx_ctrl(tx_ctrl[3]), .tx_byte(tx_byte[3]),
    .tx_serial(ser[3]), .tx_busy(busy[3]), .tx_done(done[3]), .tx_state(st[3]));

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // ---------------- monitor ----------------
  task automatic mon(input int d);
    logic        prev;
    logic [10:0] lvl;
    logic [7:0]  data;
    logic        par;
    logic [10:0] obs, e;
    int          c, n, k, glitch, done_cnt, done_at, busy_err;
    bit          abort;
    prev = 1'b1;
    forever begin
      @(negedge tb_clk);
      if (rst) begin
        prev = 1'b1;
        continue;
      end
      if (!(prev == 1'b1 && ser[d] == 1'b0)) begin
        prev = ser[d];
        continue;
      end
      // First cycle of the start bit.
      c = CPB[d];
      n = 10 + PEN[d];
      abort = 0; glitch = 0; done_cnt = 0; done_at = -1; busy_err = 0;
      lvl = '1;
      for (int t = 0; t < n * c; t++) begin
        if (t > 0) @(negedge tb_clk);
        if (rst) begin
          abort = 1;
          break;
        end
        k = t / c;
        if (t % c == 0) lvl[k] = ser[d];
        else if (ser[d] !== lvl[k]) glitch++;
        if (busy[d] !== 1'b1) busy_err++;
        if (done[d] === 1'b1) begin
          done_cnt++;
          done_at = t;
        end
      end
      if (!abort) begin
        @(negedge tb_clk);
        if (rst) abort = 1;
      end
      if (abort) begin
        prev = 1'b1;
        continue;
      end
      // CLEAN cycle: line high, not busy, no pulse.
      check($sformatf("dut%0d_clean", d), {ser[d], busy[d], done[d]}, 3'b100);
      data = lvl[8:1];
      par  = (PEN[d] != 0) ? lvl[9] : 1'b0;
      obs  = {d[1:0], par, data};
      check($sformatf("dut%0d_framing", d), {lvl[0], lvl[n-1]}, 2'b01);
      check($sformatf("dut%0d_bit_stable", d), glitch, 0);
      check($sformatf("dut%0d_busy_in_frame", d), busy_err, 0);
      check($sformatf("dut%0d_done_count", d), done_cnt, 1);
      check($sformatf("dut%0d_done_cycle", d), done_at, n * c - 1);
      if (exp_q.size() == 0) begin
        check($sformatf("dut%0d_unexpected_frame", d), obs, 11'h7FF);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("dut%0d_frame", d), obs, e);
      end
      prev = ser[d];
    end
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
      mon(3);
    join_none
  end

  // ---------------- driver tasks ----------------
  task automatic wait_busy(input int d, input logic lvl, output int t_seen);
    t_seen = -1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge tb_clk);
      #1;
      if (busy[d] === lvl) begin
        t_seen = cyc;
        return;
      end
    end
    check($sformatf("dut%0d_wait_busy_%0b_timeout", d, lvl), 0, 1);
  endtask

  task automatic send(input int d, input logic [7:0] b, input logic p);
    int t;
    exp_q.push_back({d[1:0], p, b});
    tx_byte[d] = b;
    tx_ctrl[d] = 1'b1;
    @(posedge tb_clk);
    #1;
    tx_ctrl[d] = 1'b0;
    tx_byte[d] = ~b;  // must not disturb the frame in flight
    wait_busy(d, 1'b0, t);
    repeat (3) @(posedge tb_clk);
    #1;
  endtask

  // Directed vectors for instance 0: {byte, even parity}
  logic [8:0] vec0 [8] = '{{8'h00, 1'b0}, {8'hFF, 1'b0}, {8'h01, 1'b1},
                           {8'h80, 1'b1}, {8'h3C, 1'b0}, {8'hA5, 1'b0},
                           {8'h7F, 1'b1}, {8'hAB, 1'b1}};

  // ---------------- main sequence ----------------
  initial begin
    int t1, t2, bad;
    for (int i = 0; i < 4; i++) tx_byte[i] = 8'h00;

    // Reset held for 2 cycles.
    rst = 1'b1;
    repeat (2) @(posedge tb_clk);
    #1;
    rst = 1'b0;
    check("reset_serial", ser, 4'hF);
    check("reset_busy", busy, 4'h0);
    check("reset_done", done, 4'h0);
    check("reset_state", st[0], 3'd0);
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge tb_clk);
      #1;
      if (ser !== 4'hF || busy !== 4'h0 || done !== 4'h0) bad++;
    end
    check("idle_after_reset", bad, 0);

    // Even parity, full-rate timing: 0xAB -> parity 1.
    send(3, 8'hAB, 1'b1);

    // Odd parity instance.
    send(1, 8'h00, 1'b1);
    send(1, 8'h01, 1'b0);
    send(1, 8'hFF, 1'b1);
    send(1, 8'h6E, 1'b0);

    // No-parity instance: STOP right after D7.
    send(2, 8'hFF, 1'b0);
    send(2, 8'h12, 1'b0);

    // Even parity sweep.
    for (int i = 0; i < 8; i++) send(0, vec0[i][8:1], vec0[i][0]);

    // Back-to-back with tx_ctrl held high: 0x55 then 0xC3 (both parity 0).
    exp_q.push_back({2'd0, 1'b0, 8'h55});
    exp_q.push_back({2'd0, 1'b0, 8'hC3});
    tx_byte[0] = 8'h55;
    tx_ctrl[0] = 1'b1;
    wait_busy(0, 1'b1, t1);
    tx_byte[0] = 8'hC3;
    wait_busy(0, 1'b0, t2);
    wait_busy(0, 1'b1, t2);
    tx_ctrl[0] = 1'b0;
    check("back_to_back_period", t2 - t1, 11 * 4 + 2);
    // A request pulsed mid-frame is dropped.
    repeat (10) @(posedge tb_clk);
    #1;
    tx_byte[0] = 8'hEE;
    tx_ctrl[0] = 1'b1;
    @(posedge tb_clk);
    #1;
    tx_ctrl[0] = 1'b0;
    wait_busy(0, 1'b0, t1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge tb_clk);
      #1;
      if (busy[0] !== 1'b0) bad++;
    end
    check("midframe_request_dropped", bad, 0);

    // Reset during D3 (cycles 16..19 of the frame at 4 clk/bit).
    tx_byte[0] = 8'h5A;
    tx_ctrl[0] = 1'b1;
    @(posedge tb_clk);
    #1;
    tx_ctrl[0] = 1'b0;
    repeat (17) @(posedge tb_clk);
    #1;
    check("pre_abort_busy", busy[0], 1'b1);
    rst = 1'b1;
    @(posedge tb_clk);
    #1;
    rst = 1'b0;
    check("abort_serial", ser[0], 1'b1);
    check("abort_busy", busy[0], 1'b0);
    check("abort_state", st[0], 3'd0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (done[0] !== 1'b0 || ser[0] !== 1'b1) bad++;
      @(posedge tb_clk);
      #1;
    end
    check("abort_no_done", bad, 0);
    send(0, 8'h96, 1'b0);

    repeat (5) @(posedge tb_clk);
    #1;
    check("all_expected_frames_seen", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
